// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: port count,
// default memory depth, priority-state encoding and the address check.
package dm_arb_pkg;

    localparam int          NUM_PORTS         = 2;
    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    // Which port wins when both request in the same cycle.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    // A command is an error if it is not word aligned or falls past the
    // end of memory. The limit is built in 34 bits so that large
    // MEM_WORDS values and addresses near 2^32 compare correctly.
    function automatic logic addr_is_err(input logic [31:0] addr,
                                         input int unsigned words);
        logic [33:0] limit;
        limit = 34'(words) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dm_arb_resp.sv
// Per-port response stage: registered rvalid/err/rdata strobe one cycle
// after a grant, plus a saturating count of grants to the port.
module dm_arb_resp #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gnt,
    input  logic             err_in,
    input  logic [31:0]      rdata_in,
    output logic             rvalid,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [CNT_W-1:0] cnt
);

    logic             rvalid_reg;
    logic             err_reg;
    logic [31:0]      rdata_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Capture the response of a granted command; err/rdata hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            rvalid_reg <= gnt;
            if (gnt) begin
                err_reg   <= err_in;
                rdata_reg <= rdata_in;
                if (cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign err    = err_reg;
    assign rdata  = rdata_reg;
    assign cnt    = cnt_reg;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. Grants are
// combinational with alternating tie priority; responses come back one
// cycle after the grant through a dm_arb_resp stage per port.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [31:0]      p0_rdata,
    output logic             p0_err,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [31:0]      p1_rdata,
    output logic             p1_err,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] p0_cnt,
    output logic [CNT_W-1:0] p1_cnt
);

    pri_t pri_reg, pri_next;

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] gnt_vec;
    logic [NUM_PORTS-1:0] err_vec;
    logic [NUM_PORTS-1:0] rvalid_vec;
    logic [NUM_PORTS-1:0] rerr_vec;
    logic [31:0]          addr_arr  [NUM_PORTS];
    logic [31:0]          rdata_arr [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_arr   [NUM_PORTS];

    logic        sel_we;
    logic        sel_err;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] resp_rdata;

    assign req_vec     = {p1_req, p0_req};
    assign addr_arr[0] = p0_addr;
    assign addr_arr[1] = p1_addr;

    // Grant decision: a lone requester wins, a tie goes to the priority
    // holder; nothing is granted while reset is held.
    always_comb begin
        gnt_vec = '0;
        if (!reset) begin
            if (req_vec[0] && (!req_vec[1] || pri_reg == PRI0)) begin
                gnt_vec[0] = 1'b1;
            end else if (req_vec[1]) begin
                gnt_vec[1] = 1'b1;
            end
        end
    end

    // Command mux onto the memory port; idle cycles drive all zeros and an
    // erroneous command is passed through with its write suppressed.
    always_comb begin
        sel_we    = 1'b0;
        sel_err   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_vec[0]) begin
            sel_we    = p0_we;
            sel_err   = err_vec[0];
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else if (gnt_vec[1]) begin
            sel_we    = p1_we;
            sel_err   = err_vec[1];
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    assign mem_we    = sel_we & ~sel_err;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Only a valid read returns memory data; writes and errors return zero.
    assign resp_rdata = (sel_we || sel_err) ? 32'h0 : mem_rdata;

    // Priority next state: the port just served yields the next tie.
    always_comb begin
        pri_next = pri_reg;
        if (gnt_vec[0]) begin
            pri_next = PRI1;
        end else if (gnt_vec[1]) begin
            pri_next = PRI0;
        end
    end

    // Priority state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_reg <= PRI0;
        end else begin
            pri_reg <= pri_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign err_vec[gi] = addr_is_err(addr_arr[gi], MEM_WORDS);

            dm_arb_resp #(
                .CNT_W (CNT_W)
            ) u_resp (
                .clk      (clk),
                .reset    (reset),
                .gnt      (gnt_vec[gi]),
                .err_in   (err_vec[gi]),
                .rdata_in (resp_rdata),
                .rvalid   (rvalid_vec[gi]),
                .err      (rerr_vec[gi]),
                .rdata    (rdata_arr[gi]),
                .cnt      (cnt_arr[gi])
            );
        end
    endgenerate

    assign p0_gnt    = gnt_vec[0];
    assign p1_gnt    = gnt_vec[1];
    assign p0_rvalid = rvalid_vec[0];
    assign p1_rvalid = rvalid_vec[1];
    assign p0_err    = rerr_vec[0];
    assign p1_err    = rerr_vec[1];
    assign p0_rdata  = rdata_arr[0];
    assign p1_rdata  = rdata_arr[1];
    assign p0_cnt    = cnt_arr[0];
    assign p1_cnt    = cnt_arr[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural memory, a grant/priority
// model and per-port response scoreboards.
module tb_dm_arbiter;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] p0_cnt, p1_cnt;

    // second instance with a 2-bit counter
    logic        c_p0_req, c_p0_we;
    logic [31:0] c_p0_addr, c_p0_wdata, c_mem_rdata;
    logic        c_p0_gnt, c_p0_rvalid, c_p0_err, c_p1_gnt, c_p1_rvalid, c_p1_err;
    logic [31:0] c_p0_rdata, c_p1_rdata, c_mem_addr, c_mem_wdata;
    logic        c_mem_we;
    logic [1:0]  c_p0_cnt, c_p1_cnt;
    logic        c_zero1;
    logic [31:0] c_zero32;

    logic [31:0] mem_array [0:1023];
    logic [31:0] ref_mem   [0:1023];
    logic        preload_en;

    int    tests = 0;
    int    fails = 0;
    resp_t q0[$];
    resp_t q1[$];
    resp_t last0, last1;
    logic  pri_m;
    logic [15:0] cnt_m0, cnt_m1;

    always #5 clk = ~clk;

    dm_arbiter u_dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .p0_cnt(p0_cnt), .p1_cnt(p1_cnt)
    );

    dm_arbiter #(.CNT_W(2)) u_dut_c (
        .clk(clk), .reset(reset),
        .p0_req(c_p0_req), .p0_we(c_p0_we), .p0_addr(c_p0_addr), .p0_wdata(c_p0_wdata),
        .p0_gnt(c_p0_gnt), .p0_rvalid(c_p0_rvalid), .p0_rdata(c_p0_rdata), .p0_err(c_p0_err),
        .p1_req(c_zero1), .p1_we(c_zero1), .p1_addr(c_zero32), .p1_wdata(c_zero32),
        .p1_gnt(c_p1_gnt), .p1_rvalid(c_p1_rvalid), .p1_rdata(c_p1_rdata), .p1_err(c_p1_err),
        .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata),
        .p0_cnt(c_p0_cnt), .p1_cnt(c_p1_cnt)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'h5A000000 ^ (32'(i) * 32'h00010003);
    endfunction

    // behavioural memory: combinational read, write at posedge
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 1024; i++) mem_array[i] <= pattern(i);
        end else if (mem_we) begin
            mem_array[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_array[mem_addr[11:2]];

    function automatic logic bench_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd4096);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: drive, check grant/memory side, predict the
    // response, then check both ports one cycle later against the queues.
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic g0, g1, e, w, rv;
        logic [31:0] a, d;
        resp_t rsp;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        g0 = r0 && (!r1 || pri_m == 1'b0);
        g1 = r1 && !g0;
        a  = g0 ? a0 : (g1 ? a1 : 32'h0);
        d  = g0 ? d0 : (g1 ? d1 : 32'h0);
        w  = g0 ? w0 : (g1 ? w1 : 1'b0);
        e  = (g0 || g1) && bench_err(a);
        check("p0_gnt", 32'(p0_gnt), 32'(g0));
        check("p1_gnt", 32'(p1_gnt), 32'(g1));
        check("mem_we", 32'(mem_we), 32'((g0 || g1) && w && !e));
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
        if (g0 || g1) begin
            rsp.err   = e;
            rsp.rdata = (w || e) ? 32'h0 : ref_mem[a[11:2]];
            if (w && !e) ref_mem[a[11:2]] = d;
            if (g0) begin
                q0.push_back(rsp);
                if (cnt_m0 != 16'hFFFF) cnt_m0++;
                pri_m = 1'b1;
            end else begin
                q1.push_back(rsp);
                if (cnt_m1 != 16'hFFFF) cnt_m1++;
                pri_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rv = (q0.size() != 0);
        check("p0_rvalid", 32'(p0_rvalid), 32'(rv));
        if (rv) last0 = q0.pop_front();
        check("p0_err", 32'(p0_err), 32'(last0.err));
        check("p0_rdata", p0_rdata, last0.rdata);
        check("p0_cnt", 32'(p0_cnt), 32'(cnt_m0));
        rv = (q1.size() != 0);
        check("p1_rvalid", 32'(p1_rvalid), 32'(rv));
        if (rv) last1 = q1.pop_front();
        check("p1_err", 32'(p1_err), 32'(last1.err));
        check("p1_rdata", p1_rdata, last1.rdata);
        check("p1_cnt", 32'(p1_cnt), 32'(cnt_m1));
        $display("[TB] t=%0t g0=%0b g1=%0b addr=%h we=%0b r0=%h r1=%h", $time, g0, g1, a, w && !e, p0_rdata, p1_rdata);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        last0  = '0;
        last1  = '0;
        pri_m  = 1'b0;
        cnt_m0 = '0;
        cnt_m1 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
        clear_model();
        c_zero1 = 1'b0; c_zero32 = 32'h0; c_mem_rdata = 32'h0;
        c_p0_req = 1'b0; c_p0_we = 1'b0; c_p0_addr = 32'h0; c_p0_wdata = 32'h0;
        preload_en = 1'b1;
        reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h14; p1_wdata = 32'h2;

        // reset state: grants and memory port forced low
        #1;
        check("rst_p0_gnt", 32'(p0_gnt), 32'h0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
        check("rst_p0_cnt", 32'(p0_cnt), 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        preload_en = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0;
        reset = 1'b0;

        // alternating ties after reset
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        idle();
        check("alt_p0_cnt", 32'(p0_cnt), 32'd2);
        check("alt_p1_cnt", 32'(p1_cnt), 32'd2);

        // port 0 write then read back-to-back
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd_back", p0_rdata, 32'hDEADBEEF);
        idle();
        check("rd_hold", p0_rdata, 32'hDEADBEEF);

        // error commands on port 1, plus in-range boundary
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h6, 32'hAAAA5555);
        check("mis_err", 32'(p1_err), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hBBBB6666);
        check("oob_err", 32'(p1_err), 32'h1);
        check("oob_rdata", p1_rdata, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFC, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0);
        drive(1'b1, 1'b0, 32'h2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        check("mem1_unchanged", mem_array[1], ref_mem[1]);
        check("mem0_unchanged", mem_array[0], ref_mem[0]);

        // same-address write/read contention
        drive(1'b1, 1'b1, 32'h20, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h20, 32'h2);
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("contend_rd", p0_rdata, ref_mem[8]);
        idle();
        check("mem20", mem_array[8], 32'h2);

        // reset in the middle of a write grant
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h12345678;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        #1;
        check("pre_rst_gnt", 32'(p0_gnt), 32'h1);
        check("pre_rst_we", 32'(mem_we), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(p0_gnt), 32'h0);
        check("mid_rst_we", 32'(mem_we), 32'h0);
        check("mid_rst_p0_cnt", 32'(p0_cnt), 32'h0);
        check("mid_rst_p1_cnt", 32'(p1_cnt), 32'h0);
        @(posedge clk); #1;
        check("mid_rst_p0_rv", 32'(p0_rvalid), 32'h0);
        check("mid_rst_p1_rv", 32'(p1_rvalid), 32'h0);
        check("mid_rst_mem", mem_array[16], ref_mem[16]);
        p0_req = 1'b0;
        reset = 1'b0;
        clear_model();
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0);
        idle();

        // counter saturation on the 2-bit instance
        check("sat_init", 32'(c_p0_cnt), 32'h0);
        c_p0_req = 1'b1;
        #1;
        check("sat_gnt", 32'(c_p0_gnt), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            check("sat_cnt", 32'(c_p0_cnt), (i < 3) ? 32'(i) : 32'd3);
            $display("[TB] t=%0t sat grant %0d cnt=%0d", $time, i, c_p0_cnt);
        end
        c_p0_req = 1'b0;
        @(posedge clk); #1;
        check("sat_hold", 32'(c_p0_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
